// File: rtl/flip_sched.sv
`default_nettype none
// ============================================================================
//  Module   : flip_sched
//  Purpose  : Run controller for one flip_engine. Latches a run configuration,
//             flushes the engine, meters exactly icon_num spins per pass,
//             drains the one-deep output pipe, waits for icon-finish, and
//             repeats for the configured number of passes.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i, rst_ni             clock, synchronous active-low reset
//    start_i, abort_i          run control (start sampled in IDLE only)
//    cfg_icon_num_i            spins per pass, 1..FLIP_ICON_DEPTH
//    cfg_repeat_i              pass count, 0 treated as 1
//    cfg_flip_disable_i        run the engine in bypass
//    spin_gate_o               qualifies the upstream spin valid
//    fe_spin_hs_i, fe_out_hs_i engine input / output handshakes
//    fe_icon_finish_i          engine icon-finish indication
//    fe_en_o, fe_cmpt_en_o, fe_flush_o, fe_flip_disable_o, fe_icon_last_o
//                              engine controls
//    busy_o, done_o, aborted_o, cfg_err_o, pass_cnt_o   status
// ============================================================================
module flip_sched #(
  parameter int FLIP_ICON_DEPTH = 1024,
  parameter int ADDR_W          = $clog2(FLIP_ICON_DEPTH),
  parameter int ITER_W          = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W:0]   cfg_icon_num_i,
  input  logic [ITER_W-1:0] cfg_repeat_i,
  input  logic              cfg_flip_disable_i,
  output logic              spin_gate_o,
  input  logic              fe_spin_hs_i,
  input  logic              fe_out_hs_i,
  input  logic              fe_icon_finish_i,
  output logic              fe_en_o,
  output logic              fe_cmpt_en_o,
  output logic              fe_flush_o,
  output logic              fe_flip_disable_o,
  output logic [ADDR_W:0]   fe_icon_last_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              aborted_o,
  output logic              cfg_err_o,
  output logic [ITER_W-1:0] pass_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FLUSH = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4,
    S_ABORT = 3'd5
  } state_e;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(FLIP_ICON_DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   icon_num_q, icon_num_d;
  logic [ITER_W-1:0] repeat_q, repeat_d;
  logic              flip_dis_q, flip_dis_d;
  logic [ITER_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [ADDR_W:0]   issued_q, issued_d;
  logic [ADDR_W:0]   completed_q, completed_d;

  logic en_q, en_d, cmpt_en_q, cmpt_en_d, flush_q, flush_d;
  logic busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;
  logic cfg_err_q, cfg_err_d;

  logic            cfg_ok;
  logic            issued_inc, completed_inc;
  logic [ADDR_W:0] issued_nx, completed_nx;
  logic [ITER_W:0] pass_next;
  logic            more_passes;

  // Counters saturate at icon_num, so a stray handshake can never push
  // either count past the pass length.
  assign issued_inc    = fe_spin_hs_i && (issued_q < icon_num_q);
  assign completed_inc = fe_out_hs_i && (completed_q < icon_num_q);
  assign issued_nx     = issued_q + {{ADDR_W{1'b0}}, issued_inc};
  assign completed_nx  = completed_q + {{ADDR_W{1'b0}}, completed_inc};

  assign cfg_ok      = (cfg_icon_num_i != '0) && (cfg_icon_num_i <= DEPTH_C);
  assign pass_next   = {1'b0, pass_cnt_q} + (ITER_W+1)'(1);
  assign more_passes = pass_next < {1'b0, repeat_q};

  always_comb begin
    state_d     = state_q;
    icon_num_d  = icon_num_q;
    repeat_d    = repeat_q;
    flip_dis_d  = flip_dis_q;
    pass_cnt_d  = pass_cnt_q;
    issued_d    = issued_q;
    completed_d = completed_q;
    cfg_err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // abort_i alongside start_i suppresses the start entirely
        if (start_i && !abort_i) begin
          if (cfg_ok) begin
            icon_num_d = cfg_icon_num_i;
            repeat_d   = (cfg_repeat_i == '0) ? ITER_W'(1) : cfg_repeat_i;
            flip_dis_d = cfg_flip_disable_i;
            pass_cnt_d = '0;
            state_d    = S_FLUSH;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_FLUSH: begin
        issued_d    = '0;
        completed_d = '0;
        state_d     = S_RUN;
      end
      S_RUN: begin
        issued_d    = issued_nx;
        completed_d = completed_nx;
        if (issued_nx == icon_num_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        issued_d    = issued_nx;
        completed_d = completed_nx;
        // In bypass the engine never raises icon-finish; the drained pipe
        // alone ends the pass.
        if ((completed_nx == icon_num_q) && (fe_icon_finish_i || flip_dis_q)) begin
          pass_cnt_d = pass_next[ITER_W-1:0];
          state_d    = more_passes ? S_FLUSH : S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort_i && (state_q inside {S_FLUSH, S_RUN, S_DRAIN, S_DONE})) begin
      state_d     = S_ABORT;
      pass_cnt_d  = pass_cnt_q;
      issued_d    = issued_q;
      completed_d = completed_q;
    end
  end

  // Engine controls and status pulses are decoded from the next state and
  // registered, so they line up with the state they describe.
  always_comb begin
    en_d      = state_d inside {S_FLUSH, S_RUN, S_DRAIN, S_ABORT};
    cmpt_en_d = (state_d == S_RUN);
    flush_d   = (state_d == S_FLUSH) || (state_d == S_ABORT);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    aborted_d = (state_d == S_ABORT);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      icon_num_q  <= '0;
      repeat_q    <= '0;
      flip_dis_q  <= 1'b0;
      pass_cnt_q  <= '0;
      issued_q    <= '0;
      completed_q <= '0;
      en_q        <= 1'b0;
      cmpt_en_q   <= 1'b0;
      flush_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      icon_num_q  <= icon_num_d;
      repeat_q    <= repeat_d;
      flip_dis_q  <= flip_dis_d;
      pass_cnt_q  <= pass_cnt_d;
      issued_q    <= issued_d;
      completed_q <= completed_d;
      en_q        <= en_d;
      cmpt_en_q   <= cmpt_en_d;
      flush_q     <= flush_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  // Combinational so the gate falls in the cycle right after the final
  // handshake rather than one cycle late.
  assign spin_gate_o       = (state_q == S_RUN) && (issued_q < icon_num_q);
  assign fe_en_o           = en_q;
  assign fe_cmpt_en_o      = cmpt_en_q;
  assign fe_flush_o        = flush_q;
  assign fe_flip_disable_o = flip_dis_q;
  assign fe_icon_last_o    = icon_num_q;
  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign aborted_o         = aborted_q;
  assign cfg_err_o         = cfg_err_q;
  assign pass_cnt_o        = pass_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_flip_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_flip_sched
//  Purpose  : Scoreboard bench for flip_sched with a small flip_engine model
//             (one-deep pipe, icon-finish two cycles after the last spin).
//  Revision : 1.0  initial release
// ============================================================================
module tb_flip_sched;

  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;
  localparam int ITER_W = 16;

  logic              clk = 1'b0;
  logic              rst_ni;
  logic              start_i, abort_i;
  logic [ADDR_W:0]   cfg_icon_num_i;
  logic [ITER_W-1:0] cfg_repeat_i;
  logic              cfg_flip_disable_i;
  logic              spin_gate_o;
  logic              fe_spin_hs_i, fe_out_hs_i, fe_icon_finish_i;
  logic              fe_en_o, fe_cmpt_en_o, fe_flush_o, fe_flip_disable_o;
  logic [ADDR_W:0]   fe_icon_last_o;
  logic              busy_o, done_o, aborted_o, cfg_err_o;
  logic [ITER_W-1:0] pass_cnt_o;

  flip_sched #(.FLIP_ICON_DEPTH(DEPTH), .ADDR_W(ADDR_W), .ITER_W(ITER_W)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .cfg_icon_num_i(cfg_icon_num_i), .cfg_repeat_i(cfg_repeat_i),
    .cfg_flip_disable_i(cfg_flip_disable_i), .spin_gate_o(spin_gate_o),
    .fe_spin_hs_i(fe_spin_hs_i), .fe_out_hs_i(fe_out_hs_i),
    .fe_icon_finish_i(fe_icon_finish_i), .fe_en_o(fe_en_o),
    .fe_cmpt_en_o(fe_cmpt_en_o), .fe_flush_o(fe_flush_o),
    .fe_flip_disable_o(fe_flip_disable_o), .fe_icon_last_o(fe_icon_last_o),
    .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o),
    .cfg_err_o(cfg_err_o), .pass_cnt_o(pass_cnt_o)
  );

  always #5 clk = ~clk;

  // ---------------- engine / source / sink model ----------------
  int   src_p = 100, sink_p = 100;
  logic fin_en = 1'b1;
  logic src_vld = 1'b0, sink_rdy = 1'b0;
  logic pipe_full = 1'b0, fin_d1 = 1'b0, fin_lvl = 1'b0;
  int   eng_cnt = 0;
  logic eng_ready;

  assign eng_ready        = !pipe_full || fe_out_hs_i;
  assign fe_out_hs_i      = pipe_full && sink_rdy;
  assign fe_spin_hs_i     = spin_gate_o && src_vld && eng_ready;
  assign fe_icon_finish_i = fin_lvl && fin_en;

  always @(posedge clk) begin
    #1;
    src_vld  = ($urandom_range(0, 99) < src_p);
    sink_rdy = ($urandom_range(0, 99) < sink_p);
  end

  always @(posedge clk) begin
    if (!rst_ni || fe_flush_o) begin
      pipe_full <= 1'b0;
      eng_cnt   <= 0;
      fin_d1    <= 1'b0;
      fin_lvl   <= 1'b0;
    end else begin
      pipe_full <= fe_spin_hs_i || (pipe_full && !fe_out_hs_i);
      if (fe_spin_hs_i) eng_cnt <= eng_cnt + 1;
      fin_d1  <= fe_spin_hs_i && (eng_cnt + 1 == int'(fe_icon_last_o));
      fin_lvl <= fin_lvl || fin_d1;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [2:0] kind;   // {cfg_err, aborted, done}
    logic       busy;
    int         pass;
    int         hs;
    int         flush;
    logic       flip;
    int         icon;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  int   n_tests = 0, n_fail = 0;
  int   m_icon = 0, m_pass = 0, m_licon = 0;
  logic m_flip = 1'b0, m_lflip = 1'b0;
  int   pass_hs = 0, pass_out = 0, tot_hs = 0, tot_flush = 0, viol = 0, ev_seen = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (!rst_ni) begin
      pass_hs = 0; pass_out = 0; tot_hs = 0; tot_flush = 0; viol = 0;
    end else begin
      if (spin_gate_o && pass_hs >= m_icon) viol++;
      if (busy_o && (fe_flip_disable_o !== m_flip)) viol++;
      if (fe_spin_hs_i) begin pass_hs++; tot_hs++; end
      if (fe_out_hs_i) pass_out++;
      if (fe_flush_o) begin
        if (!aborted_o && tot_flush > 0 && pass_out != m_icon) viol++;
        tot_flush++;
        pass_hs  = 0;
        pass_out = 0;
      end
      if (done_o && pass_out != m_icon) viol++;
      if (done_o || aborted_o || cfg_err_o) begin
        ev_seen++;
        if (sb_q.size() == 0) begin
          check("unexpected_event", {cfg_err_o, aborted_o, done_o}, 0);
        end else begin
          mon_e = sb_q.pop_front();
          check("event_kind",  {cfg_err_o, aborted_o, done_o}, mon_e.kind);
          check("event_busy",  busy_o, mon_e.busy);
          check("pass_cnt",    pass_cnt_o, mon_e.pass);
          check("spin_hs_tot", tot_hs, mon_e.hs);
          check("flush_tot",   tot_flush, mon_e.flush);
          check("flip_dis",    fe_flip_disable_o, mon_e.flip);
          check("icon_last",   fe_icon_last_o, mon_e.icon);
          check("gate_order",  viol, 0);
        end
        tot_hs = 0; tot_flush = 0; viol = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_event(input int budget);
    int s;
    int k;
    s = ev_seen;
    for (k = 0; k < budget; k++) begin
      @(posedge clk);
      if (ev_seen != s) break;
    end
    if (k >= budget) begin
      check("event_timeout", ev_seen - s, 1);
      sb_q.delete();
      @(negedge clk) abort_i = 1'b1;
      @(negedge clk) abort_i = 1'b0;
    end
  endtask

  task automatic drive_start(input int icon, input int rep, input logic flip, input logic ab);
    @(negedge clk);
    start_i            = 1'b1;
    abort_i            = ab;
    cfg_icon_num_i     = (ADDR_W+1)'(icon);
    cfg_repeat_i       = ITER_W'(rep);
    cfg_flip_disable_i = flip;
    @(negedge clk);
    start_i = 1'b0;
    abort_i = 1'b0;
  endtask

  task automatic run_cfg(input int icon, input int rep, input logic flip,
                         input int sp, input int kp, input logic fen, input logic poke);
    exp_t e;
    int   er;
    er = (rep == 0) ? 1 : rep;
    m_icon = icon; m_flip = flip; src_p = sp; sink_p = kp; fin_en = fen;
    e = '{kind: 3'b001, busy: 1'b1, pass: er, hs: icon * er, flush: er, flip: flip, icon: icon};
    sb_q.push_back(e);
    m_pass = er; m_licon = icon; m_lflip = flip;
    drive_start(icon, rep, flip, 1'b0);
    check("flush_at_t1", fe_flush_o, 1);
    check("busy_at_t1", busy_o, 1);
    @(negedge clk);
    check("gate_at_t2", spin_gate_o, 1);
    if (poke) begin
      start_i = 1'b1; cfg_icon_num_i = 11'd7; cfg_repeat_i = 16'd9;
      @(negedge clk) start_i = 1'b0;
    end
    wait_event(300 + icon * er * 30);
  endtask

  task automatic bad_cfg(input int icon);
    exp_t e;
    e = '{kind: 3'b100, busy: 1'b0, pass: m_pass, hs: 0, flush: 0, flip: m_lflip, icon: m_licon};
    sb_q.push_back(e);
    drive_start(icon, 1, 1'b0, 1'b0);
    check("bad_cfg_busy", busy_o, 0);
    wait_event(10);
  endtask

  initial begin
    int k;
    exp_t e;
    rst_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0;
    cfg_icon_num_i = '0; cfg_repeat_i = '0; cfg_flip_disable_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {spin_gate_o, fe_en_o, fe_cmpt_en_o, fe_flush_o, fe_flip_disable_o,
                            fe_icon_last_o, busy_o, done_o, aborted_o, cfg_err_o, pass_cnt_o}, 0);
    @(posedge clk) #1 rst_ni = 1'b1;

    // single pass, always ready
    run_cfg(4, 1, 1'b0, 100, 100, 1'b1, 1'b0);
    // repeat with sink stalls, plus an ignored start while busy
    run_cfg(3, 3, 1'b0, 100, 50, 1'b1, 1'b1);
    // bypass with icon-finish held low
    run_cfg(2, 1, 1'b1, 100, 100, 1'b0, 1'b0);
    // repeat 0 behaves as 1
    run_cfg(5, 0, 1'b0, 70, 60, 1'b1, 1'b0);
    // bad configurations
    bad_cfg(0);
    bad_cfg(DEPTH + 1);

    // missing finish: stuck in DRAIN until abort
    m_icon = 2; m_flip = 1'b0; fin_en = 1'b0; src_p = 100; sink_p = 100;
    m_pass = 0; m_licon = 2; m_lflip = 1'b0;
    k = ev_seen;
    drive_start(2, 1, 1'b0, 1'b0);
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("stuck_busy", busy_o, 1);
    check("stuck_gate", spin_gate_o, 0);
    check("stuck_no_event", ev_seen - k, 0);
    e = '{kind: 3'b010, busy: 1'b1, pass: 0, hs: 2, flush: 2, flip: 1'b0, icon: 2};
    sb_q.push_back(e);
    abort_i = 1'b1;
    @(negedge clk) abort_i = 1'b0;
    @(negedge clk);
    check("post_abort_flush", fe_flush_o, 0);
    check("post_abort_pulse", aborted_o, 0);
    check("post_abort_busy", busy_o, 0);
    check("post_abort_pass", pass_cnt_o, m_pass);
    fin_en = 1'b1;

    // start together with abort in IDLE: no start
    drive_start(3, 1, 1'b0, 1'b1);
    check("start_abort_busy", busy_o, 0);

    // reset in the middle of RUN after two handshakes
    m_icon = 4; m_flip = 1'b0; src_p = 50; sink_p = 100;
    drive_start(4, 1, 1'b0, 1'b0);
    for (k = 0; k < 200; k++) begin
      @(posedge clk);
      if (tot_hs >= 2) break;
    end
    check("reset_wait_2hs", tot_hs, 2);
    #1 rst_ni = 1'b0;
    @(posedge clk) #1 rst_ni = 1'b1;
    @(negedge clk);
    check("midrun_reset_outputs", {spin_gate_o, fe_en_o, fe_cmpt_en_o, fe_flush_o, fe_flip_disable_o,
                                   fe_icon_last_o, busy_o, done_o, aborted_o, cfg_err_o, pass_cnt_o}, 0);
    m_pass = 0; m_licon = 0; m_lflip = 1'b0;
    run_cfg(4, 1, 1'b0, 100, 100, 1'b1, 1'b0);

    // full-depth boundary
    run_cfg(DEPTH, 1, 1'b0, 100, 100, 1'b1, 1'b0);

    // randomized runs
    for (int i = 0; i < 8; i++) begin
      int   ic, rp, sp, kp;
      logic fl, fe;
      ic = $urandom_range(1, 8);
      rp = $urandom_range(0, 3);
      fl = 1'($urandom_range(0, 1));
      fe = fl ? 1'($urandom_range(0, 1)) : 1'b1;
      sp = $urandom_range(30, 100);
      kp = $urandom_range(30, 100);
      run_cfg(ic, rp, fl, sp, kp, fe, 1'($urandom_range(0, 1)));
    end
    bad_cfg(0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
